// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared divider state encodings, default width and ALU divide opcodes
package div_iter_pkg;
  localparam int DIV_DATA_W = 32;
  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_CALC   = 2'b10,
    DIV_DONE   = 2'b11
  } div_state_t;
  localparam logic [7:0] ALU_DIV  = 8'b00011010;
  localparam logic [7:0] ALU_DIVU = 8'b00011011;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (i_work={rem,quo}, i_divisor magnitude -> o_work); compare uses the bit shifted out so large remainders stay exact
module div_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] i_work,
  input  logic [W-1:0]   i_divisor,
  output logic [2*W-1:0] o_work
);
  logic [2*W:0] w_sh;
  logic         w_ge;
  logic [W-1:0] w_diff;
  assign w_sh   = {i_work, 1'b0};
  assign w_ge   = w_sh[2*W:W] >= {1'b0, i_divisor};
  assign w_diff = w_sh[2*W-1:W] - i_divisor;
  assign o_work = w_ge ? {w_diff, w_sh[W-1:1], 1'b1} : w_sh[2*W-1:0];
endmodule

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 divider; in clk,rst,signed_div,opdata1,opdata2,start,annul; out result={hi rem,lo quo},ready (both registered)
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div,
  input  logic [DATA_W-1:0]   opdata1,
  input  logic [DATA_W-1:0]   opdata2,
  input  logic                start,
  input  logic                annul,
  output logic [2*DATA_W-1:0] result,
  output logic                ready
);
  div_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_work;
  logic [DATA_W-1:0]   r_dvs;
  logic                r_sgn, r_s1, r_s2;
  logic [2*DATA_W-1:0] w_next;
  logic [DATA_W-1:0]   w_a1, w_a2, w_q, w_r;
  assign w_a1 = (signed_div & opdata1[DATA_W-1]) ? -opdata1 : opdata1;
  assign w_a2 = (signed_div & opdata2[DATA_W-1]) ? -opdata2 : opdata2;
  assign w_q  = (r_sgn & (r_s1 ^ r_s2)) ? -w_next[DATA_W-1:0] : w_next[DATA_W-1:0];
  assign w_r  = (r_sgn & r_s1) ? -w_next[2*DATA_W-1:DATA_W] : w_next[2*DATA_W-1:DATA_W];
  div_step #(.W(DATA_W)) u_step (
    .i_work    (r_work),
    .i_divisor (r_dvs),
    .o_work    (w_next)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
      r_dvs   <= '0;
      r_sgn   <= 1'b0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
    end else if (annul && r_state != DIV_IDLE) begin
      r_state <= DIV_IDLE;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          ready  <= 1'b0;
          result <= '0;
          if (start && !annul) begin
            if (opdata2 == '0) r_state <= DIV_BYZERO;
            else begin
              r_sgn   <= signed_div;
              r_s1    <= opdata1[DATA_W-1];
              r_s2    <= opdata2[DATA_W-1];
              r_work  <= {{DATA_W{1'b0}}, w_a1};
              r_dvs   <= w_a2;
              r_cnt   <= '0;
              r_state <= DIV_CALC;
            end
          end
        end
        DIV_BYZERO: begin
          result  <= '0;
          ready   <= 1'b1;
          r_state <= DIV_DONE;
        end
        DIV_CALC: begin
          r_work <= w_next;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            result  <= {w_r, w_q};
            ready   <= 1'b1;
            r_state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (!start) begin
            ready   <= 1'b0;
            result  <= '0;
            r_state <= DIV_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: table-driven and scoreboard checks of div_iter latency, results, hold, annul and reset
module tb_div_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  int          total = 0;
  int          bad = 0;
  logic [63:0] sb[$];
  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[12];
  div_iter dut (
    .clk        (clk),
    .rst        (rst),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .start      (start),
    .annul      (annul),
    .result     (result),
    .ready      (ready)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2;
    logic [31:0] q, r;
    if (b == 0) return 64'h0;
    if (sd) begin
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      q   = 32'(sa / sb2);
      r   = 32'(sa % sb2);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b, input int hold, input logic [63:0] exp);
    int n;
    int lat;
    logic [63:0] got;
    logic [63:0] want;
    lat = (b == 0) ? 1 : 32;
    signed_div = sd;
    opdata1 = a;
    opdata2 = b;
    start = 1'b1;
    sb.push_back(exp);
    tick();
    opdata1 = $urandom;
    opdata2 = $urandom;
    signed_div = ~sd;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    want = sb.pop_front();
    got = result;
    chk("result", got, want);
    repeat (hold) begin
      tick();
      chk("hold_ready", 64'(ready), 64'd1);
      chk("hold_result", result, got);
    end
    start = 1'b0;
    tick();
    chk("drop_ready", 64'(ready), 64'd0);
    chk("drop_result", result, 64'h0);
  endtask
  task automatic quiet(input string nm, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      tick();
      if (ready) seen++;
    end
    chk(nm, 64'(seen), 64'd0);
  endtask
  initial begin
    tbl[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}};
    tbl[1]  = '{1'b1, 32'hFFFFFFF9,   32'h2,          {32'hFFFFFFFF, 32'hFFFFFFFD}};
    tbl[2]  = '{1'b0, 32'hFFFFFFF9,   32'h2,          {32'h1, 32'h7FFFFFFC}};
    tbl[3]  = '{1'b1, 32'd5,          32'd0,          64'h0};
    tbl[4]  = '{1'b0, 32'd5,          32'd0,          64'h0};
    tbl[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0, 32'h80000000}};
    tbl[6]  = '{1'b0, 32'hFFFFFFFF,   32'h80000001,   {32'h7FFFFFFE, 32'h1}};
    tbl[7]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'h1, 32'hFFFFFFFD}};
    tbl[8]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF, 32'h3}};
    tbl[9]  = '{1'b0, 32'd0,          32'd5,          64'h0};
    tbl[10] = '{1'b1, 32'd100,        32'd7,          {32'd2, 32'd14}};
    tbl[11] = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'h0, 32'hFFFFFFFF}};
    repeat (2) tick();
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'h0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) run_op(tbl[i].sd, tbl[i].a, tbl[i].b, (i == 0) ? 5 : i % 3, tbl[i].exp);
    for (int i = 0; i < 8; i++) begin
      logic sd;
      logic [31:0] a, b;
      sd = 1'($urandom);
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      run_op(sd, a, b, i % 2, model(sd, a, b));
    end
    annul = 1'b1;
    signed_div = 1'b0;
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start = 1'b1;
    repeat (3) begin
      tick();
      chk("annul_idle_state", 64'(dut.r_state), 64'd0);
    end
    annul = 1'b0;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    repeat (9) tick();
    annul = 1'b1;
    tick();
    chk("annul_state", 64'(dut.r_state), 64'd0);
    chk("annul_ready", 64'(ready), 64'd0);
    annul = 1'b0;
    start = 1'b0;
    quiet("annul_no_ready", 40);
    start = 1'b1;
    tick();
    repeat (19) tick();
    rst = 1'b1;
    tick();
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_result", result, 64'h0);
    chk("rst_state", 64'(dut.r_state), 64'd0);
    rst = 1'b0;
    start = 1'b0;
    quiet("rst_no_ready", 40);
    run_op(1'b0, 32'd9, 32'd3, 1, {32'd0, 32'd3});
    run_op(1'b1, 32'd5, 32'd0, 0, 64'h0);
    run_op(1'b1, 32'hFFFFFF9C, 32'd7, 0, {32'hFFFFFFFE, 32'hFFFFFFF2});
    if (sb.size() != 0) chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
